decode_stage_v2: RTL and testbench

DECODE_STAGE_V2 -- requirements
Module: decode_stage_v2

---
 rtl/decode_stage_v2.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_stage_v2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_v2.sv
// Instruction decode stage: internal register file with optional WB bypass,
// control decode, combinational jump resolution and an end-of-program drain FSM.
module decode_stage_v2 #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int BYPASS       = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_valid,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_halt,
  output logic [DATA_W-1:0] o_ra,
  output logic [DATA_W-1:0] o_rb,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_opcode,
  output logic [5:0]        o_funct,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_valid,
  output logic [1:0]        o_ctl_wb,
  output logic [4:0]        o_ctl_mem,
  output logic [3:0]        o_ctl_ex,
  output logic              o_jump,
  output logic [DATA_W-1:0] o_jump_addr,
  output logic [1:0]        o_reg_in_jump,
  output logic [4:0]        o_rs_wire,
  output logic [4:0]        o_rt_wire,
  output logic [1:0]        o_state,
  output logic              o_program_end
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_q [32];

  logic [31:0]       eff;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt;
  logic [DATA_W-1:0] imm_d, ra_val, rb_val, br_target;
  logic              is_r, is_j, is_jal, is_beq, is_bne, is_jr, is_jalr, is_branch;
  logic              bubble, is_end;
  logic [1:0]        wb_d, alu_op;
  logic [4:0]        mem_d;
  logic [3:0]        ex_d;

  // Anything outside RUN or an empty slot decodes as the all-zero bubble word.
  assign eff    = (state_q == ST_RUN && i_valid) ? i_instr : 32'h0;
  assign op     = eff[31:26];
  assign funct  = eff[5:0];
  assign rs     = eff[25:21];
  assign rt     = eff[20:16];
  assign imm_d  = {{(DATA_W-16){eff[15]}}, eff[15:0]};
  assign is_end = (eff == 32'hFFFF_FFFF);
  assign bubble = i_flush | i_stall | (eff == 32'h0) | is_end;

  assign is_r      = (op == 6'b000000);
  assign is_j      = (op == 6'b000010);
  assign is_jal    = (op == 6'b000011);
  assign is_beq    = (op == 6'b000100);
  assign is_bne    = (op == 6'b000101);
  assign is_jr     = is_r && (funct == 6'h08);
  assign is_jalr   = is_r && (funct == 6'h09);
  assign is_branch = (op == 6'b000001) || (op[5:2] == 4'b0001);

  assign o_rs_wire = i_instr[25:21];
  assign o_rt_wire = i_instr[20:16];

  always_comb begin
    ra_val = rf_q[rs];
    if (rs == 5'd0)
      ra_val = '0;
    else if (BYPASS != 0 && i_wb_we && i_wb_addr == rs)
      ra_val = i_wb_data;
  end

  always_comb begin
    rb_val = rf_q[rt];
    if (rt == 5'd0)
      rb_val = '0;
    else if (BYPASS != 0 && i_wb_we && i_wb_addr == rt)
      rb_val = i_wb_data;
  end

  always_comb begin
    wb_d   = 2'b00;
    mem_d  = 5'b00000;
    ex_d   = 4'b0000;
    alu_op = 2'b01;
    if (is_r) begin
      wb_d = {1'b1, funct != 6'h08};
      ex_d = {1'b1, (funct == 6'h09) ? 2'b00 : 2'b10, 1'b0};
    end else begin
      if (op[5]) begin
        mem_d  = {~op[3], op[3], op[2], op[1:0]};
        alu_op = 2'b00;
      end
      if (op[5:3] == 3'b100) begin
        wb_d = 2'b01;
      end else if (op[5:3] == 3'b001) begin
        wb_d   = 2'b11;
        alu_op = 2'b11;
      end else if (is_jal) begin
        wb_d   = 2'b11;
        alu_op = 2'b00;
      end else if (op[5:3] == 3'b101 || is_branch) begin
        wb_d = 2'b10;
      end
      ex_d = {1'b0, alu_op, 1'b1};
    end
  end

  assign br_target = i_pc + (imm_d << 2);

  always_comb begin
    o_jump        = 1'b0;
    o_jump_addr   = '0;
    o_reg_in_jump = 2'b00;
    if (is_beq || is_bne) begin
      o_reg_in_jump = 2'b01;
      o_jump_addr   = br_target;
      o_jump        = is_beq ? (ra_val == rb_val) : (ra_val != rb_val);
    end
    if (is_j || is_jal) begin
      o_jump      = 1'b1;
      o_jump_addr = {i_pc[DATA_W-1:28], eff[25:0], 2'b00};
    end
    if (is_jr || is_jalr) begin
      o_jump        = 1'b1;
      o_jump_addr   = ra_val;
      o_reg_in_jump = 2'b10;
    end
    if (state_q != ST_RUN || !i_valid || i_stall || i_flush)
      o_jump = 1'b0;
  end

  // Write-back lands regardless of halt so the pipeline behind us can retire.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (i_wb_we && i_wb_addr != 5'd0) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ra <= '0; o_rb <= '0; o_imm <= '0;
      o_rs <= '0; o_rt <= '0; o_rd <= '0; o_shamt <= '0;
      o_opcode <= '0; o_funct <= '0; o_valid <= 1'b0;
      o_ctl_wb <= '0; o_ctl_mem <= '0; o_ctl_ex <= '0;
    end else if (!i_halt) begin
      o_ra      <= (is_jal || is_jalr) ? i_pc : ra_val;
      o_rb      <= (is_jal || is_jalr) ? DATA_W'(4) : rb_val;
      o_rt      <= (is_jal || is_jalr) ? 5'd0 : rt;
      o_rd      <= is_jal ? 5'd31 : eff[15:11];
      o_rs      <= rs;
      o_shamt   <= eff[10:6];
      o_opcode  <= op;
      o_funct   <= funct;
      o_imm     <= imm_d;
      o_valid   <= !bubble;
      o_ctl_wb  <= bubble ? 2'b00 : wb_d;
      o_ctl_mem <= bubble ? 5'b00000 : mem_d;
      o_ctl_ex  <= bubble ? 4'b0000 : ex_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_halt) begin
      case (state_q)
        ST_RUN: begin
          if (is_end && !i_stall && !i_flush) begin
            state_d = ST_DRAIN;
            cnt_d   = 4'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_DONE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  assign o_state       = state_q;
  assign o_program_end = (state_q == ST_DONE);

endmodule

// File: tb/tb_decode_stage_v2.sv
// Directed bench for decode_stage_v2: a bypassing instance and a non-bypassing
// instance share the same stimulus; control words go through an expected queue.
module tb_decode_stage_v2;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset, i_valid, i_wb_we, i_stall, i_flush, i_halt;
  logic [31:0]   i_instr;
  logic [DW-1:0] i_pc, i_wb_data;
  logic [4:0]    i_wb_addr;

  logic [DW-1:0] o_ra, o_rb, o_imm, o_jump_addr;
  logic [4:0]    o_rs, o_rt, o_rd, o_shamt, o_ctl_mem, o_rs_wire, o_rt_wire;
  logic [5:0]    o_opcode, o_funct;
  logic          o_valid, o_jump, o_program_end;
  logic [1:0]    o_ctl_wb, o_reg_in_jump, o_state;
  logic [3:0]    o_ctl_ex;

  logic [DW-1:0] nb_ra, nb_rb, nb_imm, nb_jump_addr;
  logic [4:0]    nb_rs, nb_rt, nb_rd, nb_shamt, nb_ctl_mem, nb_rs_wire, nb_rt_wire;
  logic [5:0]    nb_opcode, nb_funct;
  logic          nb_valid, nb_jump, nb_program_end;
  logic [1:0]    nb_ctl_wb, nb_reg_in_jump, nb_state;
  logic [3:0]    nb_ctl_ex;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [11:0]   exp_q[$];

  always #5 i_clk = ~i_clk;

  decode_stage_v2 #(.DATA_W(DW), .DRAIN_CYCLES(4), .BYPASS(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_pc(i_pc), .i_valid(i_valid),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
    .o_ra(o_ra), .o_rb(o_rb), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_opcode(o_opcode), .o_funct(o_funct), .o_imm(o_imm), .o_valid(o_valid),
    .o_ctl_wb(o_ctl_wb), .o_ctl_mem(o_ctl_mem), .o_ctl_ex(o_ctl_ex),
    .o_jump(o_jump), .o_jump_addr(o_jump_addr), .o_reg_in_jump(o_reg_in_jump),
    .o_rs_wire(o_rs_wire), .o_rt_wire(o_rt_wire), .o_state(o_state),
    .o_program_end(o_program_end)
  );

  decode_stage_v2 #(.DATA_W(DW), .DRAIN_CYCLES(4), .BYPASS(0)) dut_nb (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_pc(i_pc), .i_valid(i_valid),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
    .o_ra(nb_ra), .o_rb(nb_rb), .o_rs(nb_rs), .o_rt(nb_rt), .o_rd(nb_rd), .o_shamt(nb_shamt),
    .o_opcode(nb_opcode), .o_funct(nb_funct), .o_imm(nb_imm), .o_valid(nb_valid),
    .o_ctl_wb(nb_ctl_wb), .o_ctl_mem(nb_ctl_mem), .o_ctl_ex(nb_ctl_ex),
    .o_jump(nb_jump), .o_jump_addr(nb_jump_addr), .o_reg_in_jump(nb_reg_in_jump),
    .o_rs_wire(nb_rs_wire), .o_rt_wire(nb_rt_wire), .o_state(nb_state),
    .o_program_end(nb_program_end)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive the IF/ID slot and let the combinational outputs settle.
  task automatic drive(input logic [31:0] ins, input logic [DW-1:0] pc, input logic v);
    i_instr = ins;
    i_pc    = pc;
    i_valid = v;
    #1;
  endtask

  // Expected {valid, wb[1:0], ex[3:0], mem[4:0]} after the next edge.
  task automatic decode(input string tag, input logic [11:0] exp_ctl);
    exp_q.push_back(exp_ctl);
    tick();
    check(tag, {o_valid, o_ctl_wb, o_ctl_ex, o_ctl_mem}, exp_q.pop_front());
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [DW-1:0] d);
    i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    tick();
    i_wb_we = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_wb_we = 1'b0; i_stall = 1'b0;
    i_flush = 1'b0; i_halt = 1'b0; i_instr = 32'h0; i_pc = '0;
    i_wb_addr = 5'd0; i_wb_data = '0;
    tick(); tick();
    check("rst_state", o_state, 2'b00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_ra", o_ra, 0);
    check("rst_end", o_program_end, 1'b0);
    i_reset = 1'b0;

    // ADD r3,r5,r6 after writing r5/r6
    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h22);
    drive(32'h00A6_1820, 32'h40, 1'b1);
    check("add_rs_wire", o_rs_wire, 5);
    check("add_rt_wire", o_rt_wire, 6);
    check("add_jump", o_jump, 1'b0);
    decode("add_ctl", {1'b1, 2'b11, 4'b1100, 5'b00000});
    check("add_ra", o_ra, 32'h11);
    check("add_rb", o_rb, 32'h22);
    check("add_rd", o_rd, 3);
    check("add_funct", o_funct, 6'h20);

    // BEQ r7,r7,+3 with same-cycle WB r7=0xAB
    i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hAB;
    drive(32'h10E7_0003, 32'h100, 1'b1);
    check("beq_jump", o_jump, 1'b1);
    check("beq_addr", o_jump_addr, 32'h10C);
    check("beq_rij", o_reg_in_jump, 2'b01);
    check("beq_nb_jump", nb_jump, 1'b1);
    check("beq_nb_addr", nb_jump_addr, 32'h10C);
    decode("beq_ctl", {1'b1, 2'b10, 4'b0011, 5'b00000});
    i_wb_we = 1'b0;
    check("beq_ra_bypass", o_ra, 32'hAB);
    check("beq_ra_nobypass", nb_ra, 32'h0);
    check("beq_imm", o_imm, 32'h3);

    drive(32'h14E7_0003, 32'h100, 1'b1);
    check("bne_eq_jump", o_jump, 1'b0);
    drive(32'h14A7_0003, 32'h100, 1'b1);
    check("bne_ne_jump", o_jump, 1'b1);
    check("bne_ne_nb_jump", nb_jump, 1'b1);
    decode("bne_ctl", {1'b1, 2'b10, 4'b0011, 5'b00000});

    // LHU with stall, then released
    i_stall = 1'b1;
    drive(32'h94A8_FFFC, 32'h0, 1'b1);
    decode("lhu_stall", 12'h000);
    i_stall = 1'b0;
    decode("lhu_ctl", {1'b1, 2'b01, 4'b0001, 5'b10101});
    check("lhu_imm", o_imm, 32'hFFFF_FFFC);
    check("lhu_ra", o_ra, 32'h11);

    // Halt freezes the stage, but the WB write still lands
    i_halt = 1'b1;
    i_wb_we = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h99;
    drive(32'h00A6_1820, 32'h40, 1'b1);
    decode("halt_hold", {1'b1, 2'b01, 4'b0001, 5'b10101});
    check("halt_imm", o_imm, 32'hFFFF_FFFC);
    i_halt = 1'b0; i_wb_we = 1'b0;

    // JR r9, then flushed
    drive(32'h0120_0008, 32'h300, 1'b1);
    check("jr_jump", o_jump, 1'b1);
    check("jr_addr", o_jump_addr, 32'h99);
    check("jr_rij", o_reg_in_jump, 2'b10);
    decode("jr_ctl", {1'b1, 2'b10, 4'b1100, 5'b00000});
    i_flush = 1'b1;
    drive(32'h0120_0008, 32'h300, 1'b1);
    check("flush_jump", o_jump, 1'b0);
    decode("flush_ctl", 12'h000);
    i_flush = 1'b0;

    // JAL 0x40 at pc 0x8, then JALR r9
    drive(32'h0C00_0040, 32'h8, 1'b1);
    check("jal_jump", o_jump, 1'b1);
    check("jal_addr", o_jump_addr, 32'h100);
    decode("jal_ctl", {1'b1, 2'b11, 4'b0001, 5'b00000});
    check("jal_ra", o_ra, 32'h8);
    check("jal_rb", o_rb, 32'h4);
    check("jal_rd", o_rd, 31);
    check("jal_rt", o_rt, 0);
    drive(32'h0120_F809, 32'h200, 1'b1);
    check("jalr_addr", o_jump_addr, 32'h99);
    decode("jalr_ctl", {1'b1, 2'b11, 4'b1000, 5'b00000});
    check("jalr_ra", o_ra, 32'h200);
    check("jalr_rb", o_rb, 32'h4);

    // ADDI, SW, empty slot
    drive(32'h20A2_0007, 32'h0, 1'b1);
    decode("addi_ctl", {1'b1, 2'b11, 4'b0111, 5'b00000});
    drive(32'hACA8_0010, 32'h0, 1'b1);
    decode("sw_ctl", {1'b1, 2'b10, 4'b0001, 5'b01011});
    drive(32'h00A6_1820, 32'h0, 1'b0);
    decode("invalid_ctl", 12'h000);

    // End marker: DRAIN for 4 cycles plus one halted cycle, then DONE
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    decode("end_ctl", 12'h000);
    check("drain_enter", o_state, 2'b01);
    check("end_opcode", o_opcode, 6'h3F);
    drive(32'h00A6_1820, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      i_halt = (i == 0);
      tick();
      check("drain_state", o_state, 2'b01);
      check("drain_valid", o_valid, 1'b0);
    end
    i_halt = 1'b0;
    tick();
    check("done_state", o_state, 2'b10);
    check("done_end", o_program_end, 1'b1);
    drive(32'h0120_0008, 32'h0, 1'b1);
    check("done_jump", o_jump, 1'b0);
    decode("done_ctl", 12'h000);
    check("done_stay", o_state, 2'b10);

    // Reset clears DONE; reset during DRAIN (with halt) clears everything
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rst_done_state", o_state, 2'b00);
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    tick();
    check("drain2_state", o_state, 2'b01);
    i_reset = 1'b1; i_halt = 1'b1;
    drive(32'h00A6_1820, 32'h0, 1'b1);
    tick();
    i_reset = 1'b0; i_halt = 1'b0;
    check("rst_drain_state", o_state, 2'b00);
    check("rst_drain_opcode", o_opcode, 0);
    check("rst_drain_imm", o_imm, 0);
    check("rst_drain_ctl", {o_valid, o_ctl_wb, o_ctl_ex, o_ctl_mem}, 0);
    drive(32'h00A6_1820, 32'h0, 1'b1);
    decode("post_rst_ctl", {1'b1, 2'b11, 4'b1100, 5'b00000});
    check("post_rst_ra", o_ra, 0);
    check("post_rst_rb", o_rb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
